// File: rtl/score4_move_sequencer.sv
// Move sequencer for the score4 core: arbitrates human and automated moves,
// expands an automated column choice into timed left/right/put pulses.
module score4_move_sequencer #(
    parameter int NCOLS      = 7,
    parameter int COL_START  = 3,
    parameter int PULSE_LEN  = 3,
    parameter int GAP_LEN    = 4,
    parameter int SETTLE_LEN = 8,
    parameter int FRAME_SYNC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_left,
    input  logic       h_right,
    input  logic       h_put,
    input  logic       auto_valid,
    input  logic [2:0] auto_col,
    output logic       auto_ready,
    input  logic       player,
    input  logic       invalid_move,
    input  logic       win_a,
    input  logic       win_b,
    input  logic       full_panel,
    input  logic       vsync,
    output logic       left,
    output logic       right,
    output logic       put,
    output logic [2:0] cursor,
    output logic       busy,
    output logic       err_col,
    output logic       game_over
);
    localparam logic [2:0] CMAX   = 3'(NCOLS - 1);
    localparam logic [2:0] COL0   = 3'(COL_START);
    localparam logic [7:0] P_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] G_LAST = 8'(GAP_LEN - 1);
    localparam logic [7:0] S_LAST = 8'(SETTLE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_GAP, S_PUT, S_SETTLE, S_ARM, S_OVER
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] cursor_q, cursor_d;
    logic [2:0] target_q, target_d;
    logic       dir_q, dir_d;
    logic       auto_seq_q, auto_seq_d;
    logic       arm_put_q, arm_put_d;
    logic       vsync_q;
    logic       left_q, left_d, right_q, right_d, put_q, put_d;
    logic       busy_q, busy_d, err_col_q, err_col_d, game_over_q, game_over_d;
    logic       status, frame_ok, launch_step, launch_put;

    assign status   = win_a | win_b | full_panel;
    assign frame_ok = (FRAME_SYNC == 0) || (vsync_q && !vsync);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cursor_d    = cursor_q;
        target_d    = target_q;
        dir_d       = dir_q;
        auto_seq_d  = auto_seq_q;
        arm_put_d   = arm_put_q;
        err_col_d   = 1'b0;
        launch_step = 1'b0;
        launch_put  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (status) begin
                    state_d = S_OVER;
                end else if (player) begin
                    if (auto_valid) begin
                        if (auto_col > CMAX) begin
                            err_col_d = 1'b1;
                        end else begin
                            auto_seq_d = 1'b1;
                            target_d   = auto_col;
                            dir_d      = auto_col > cursor_q;
                            if (auto_col == cursor_q) launch_put  = 1'b1;
                            else                      launch_step = 1'b1;
                        end
                    end
                end else begin
                    // put > left > right; a blocked left swallows the right
                    auto_seq_d = 1'b0;
                    if (h_put) begin
                        launch_put = 1'b1;
                    end else if (h_left) begin
                        if (cursor_q != 3'd0) begin
                            dir_d       = 1'b0;
                            launch_step = 1'b1;
                        end
                    end else if (h_right && cursor_q != CMAX) begin
                        dir_d       = 1'b1;
                        launch_step = 1'b1;
                    end
                end
            end
            S_STEP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_GAP;
                    cnt_d   = G_LAST;
                    if (dir_q && cursor_q != CMAX)       cursor_d = cursor_q + 3'd1;
                    else if (!dir_q && cursor_q != 3'd0) cursor_d = cursor_q - 3'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 8'd0) begin
                    if (!auto_seq_q)             state_d     = S_IDLE;
                    else if (cursor_q == target_q) launch_put  = 1'b1;
                    else                         launch_step = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PUT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_SETTLE;
                    cnt_d   = S_LAST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    if (status) begin
                        state_d = S_OVER;
                    end else begin
                        err_col_d = invalid_move && auto_seq_q;
                        state_d   = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ARM: begin
                if (frame_ok) begin
                    state_d = arm_put_q ? S_PUT : S_STEP;
                    cnt_d   = P_LAST;
                end
            end
            default: ;
        endcase
        // Pulses start immediately, or park in ARM until the frame boundary
        if (launch_step || launch_put) begin
            if (frame_ok) begin
                state_d = launch_put ? S_PUT : S_STEP;
                cnt_d   = P_LAST;
            end else begin
                state_d   = S_ARM;
                arm_put_d = launch_put;
            end
        end
        left_d      = (state_d == S_STEP) && !dir_d;
        right_d     = (state_d == S_STEP) && dir_d;
        put_d       = (state_d == S_PUT);
        busy_d      = (state_d != S_IDLE) && (state_d != S_OVER);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            cursor_q    <= COL0;
            target_q    <= COL0;
            dir_q       <= 1'b0;
            auto_seq_q  <= 1'b0;
            arm_put_q   <= 1'b0;
            vsync_q     <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            put_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_col_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cursor_q    <= cursor_d;
            target_q    <= target_d;
            dir_q       <= dir_d;
            auto_seq_q  <= auto_seq_d;
            arm_put_q   <= arm_put_d;
            vsync_q     <= vsync;
            left_q      <= left_d;
            right_q     <= right_d;
            put_q       <= put_d;
            busy_q      <= busy_d;
            err_col_q   <= err_col_d;
            game_over_q <= game_over_d;
        end
    end

    assign auto_ready = rst && player && (state_q == S_IDLE);
    assign left       = left_q;
    assign right      = right_q;
    assign put        = put_q;
    assign cursor     = cursor_q;
    assign busy       = busy_q;
    assign err_col    = err_col_q;
    assign game_over  = game_over_q;
endmodule

// File: tb/tb_score4_move_sequencer.sv
// Bench for score4_move_sequencer: a per-cycle expected-output schedule built
// from move requests, checked every cycle, plus a FRAME_SYNC=1 instance.
module tb_score4_move_sequencer;
    localparam int PULSE = 3, GAP = 4, SETTLE = 8;

    logic clk, rst;
    logic h_left, h_right, h_put, auto_valid, player, invalid_move;
    logic win_a, win_b, full_panel, vsync;
    logic [2:0] auto_col;
    logic left, right, put, busy, err_col, game_over, auto_ready;
    logic [2:0] cursor;
    logic fs_h_put, zero;
    logic [2:0] zero3;
    logic fs_left, fs_right, fs_put, fs_busy, fs_err, fs_over, fs_ready;
    logic [2:0] fs_cursor;

    score4_move_sequencer dut (
        .clk(clk), .rst(rst), .h_left(h_left), .h_right(h_right), .h_put(h_put),
        .auto_valid(auto_valid), .auto_col(auto_col), .auto_ready(auto_ready),
        .player(player), .invalid_move(invalid_move), .win_a(win_a), .win_b(win_b),
        .full_panel(full_panel), .vsync(vsync), .left(left), .right(right), .put(put),
        .cursor(cursor), .busy(busy), .err_col(err_col), .game_over(game_over)
    );

    score4_move_sequencer #(.FRAME_SYNC(1)) u_fs (
        .clk(clk), .rst(rst), .h_left(zero), .h_right(zero), .h_put(fs_h_put),
        .auto_valid(zero), .auto_col(zero3), .auto_ready(fs_ready),
        .player(zero), .invalid_move(zero), .win_a(zero), .win_b(zero),
        .full_panel(zero), .vsync(vsync), .left(fs_left), .right(fs_right), .put(fs_put),
        .cursor(fs_cursor), .busy(fs_busy), .err_col(fs_err), .game_over(fs_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic l, r, p, b, e, rdy, go;
        logic [2:0] cur;
    } exp_t;

    exp_t q[$];
    exp_t ex;
    logic [2:0] mdl_cursor;
    logic mdl_over, chk_en;
    logic prev_l, prev_r, prev_p, prev_e;
    int total, bad;
    int left_rises, right_rises, put_rises, err_rises;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    task automatic push(input logic l, r, p, b, e, rdy, go, input logic [2:0] cur);
        exp_t x;
        x.l = l; x.r = r; x.p = p; x.b = b; x.e = e; x.rdy = rdy; x.go = go; x.cur = cur;
        q.push_back(x);
    endtask

    // Expected output per cycle for a move: n step pulses (each followed by a
    // gap), optional put + settle, then the first idle cycle.
    task automatic sched(input bit go_right, input int steps, input bit do_put,
                         input bit err_end, input bit win_end);
        logic [2:0] c;
        c = mdl_cursor;
        for (int s = 0; s < steps; s++) begin
            for (int i = 0; i < PULSE; i++) push(!go_right, go_right, 0, 1, 0, 0, 0, c);
            c = go_right ? c + 3'd1 : c - 3'd1;
            for (int i = 0; i < GAP; i++) push(0, 0, 0, 1, 0, 0, 0, c);
        end
        if (do_put) begin
            for (int i = 0; i < PULSE; i++) push(0, 0, 1, 1, 0, 0, 0, c);
            for (int i = 0; i < SETTLE; i++) push(0, 0, 0, 1, 0, 0, 0, c);
        end
        push(0, 0, 0, 0, err_end, player && !win_end, win_end, c);
        mdl_cursor = c;
        if (win_end) mdl_over = 1'b1;
    endtask

    task automatic cmp_cycle();
        if (q.size() > 0) ex = q.pop_front();
        else begin
            ex.l = 0; ex.r = 0; ex.p = 0; ex.b = 0; ex.e = 0;
            ex.rdy = rst && player && !mdl_over; ex.go = mdl_over; ex.cur = mdl_cursor;
        end
        chk("left", left, ex.l);
        chk("right", right, ex.r);
        chk("put", put, ex.p);
        chk("busy", busy, ex.b);
        chk("err_col", err_col, ex.e);
        chk("auto_ready", auto_ready, ex.rdy);
        chk("game_over", game_over, ex.go);
        chk("cursor", cursor, ex.cur);
        if (left && !prev_l) left_rises++;
        if (right && !prev_r) right_rises++;
        if (put && !prev_p) put_rises++;
        if (err_col && !prev_e) err_rises++;
        prev_l = left; prev_r = right; prev_p = put; prev_e = err_col;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (chk_en) cmp_cycle();
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0) begin
            if (n >= 400) begin
                total++; bad++;
                $display("FAIL wait_idle: %0d entries left, expected 0", q.size());
                q.delete();
                break;
            end
            cyc();
            n++;
        end
    endtask

    task automatic human(input bit l, input bit r, input bit p, input bit win);
        h_left = l; h_right = r; h_put = p;
        if (!mdl_over && q.size() == 0 && !player && rst) begin
            if (p) sched(0, 0, 1, 0, win);
            else if (l) begin
                if (mdl_cursor != 3'd0) sched(0, 1, 0, 0, 0);
            end else if (r && mdl_cursor != 3'd6) sched(1, 1, 0, 0, 0);
        end
        cyc();
        h_left = 0; h_right = 0; h_put = 0;
    endtask

    task automatic auto_move(input logic [2:0] col, input bit inv);
        int steps;
        auto_valid = 1; auto_col = col; invalid_move = inv;
        if (!mdl_over && q.size() == 0 && player && rst) begin
            if (col >= 3'd7) push(0, 0, 0, 0, 1, 1, 0, mdl_cursor);
            else begin
                steps = (col > mdl_cursor) ? int'(col - mdl_cursor) : int'(mdl_cursor - col);
                sched(col > mdl_cursor, steps, 1, inv, 0);
            end
        end
        cyc();
        auto_valid = 0;
    endtask

    task automatic do_reset();
        rst = 0; win_a = 0;
        q.delete();
        mdl_cursor = 3'd3;
        mdl_over = 1'b0;
    endtask

    initial begin
        int r0, p0, e0;
        rst = 0; h_left = 0; h_right = 0; h_put = 0; auto_valid = 0; auto_col = 0;
        player = 0; invalid_move = 0; win_a = 0; win_b = 0; full_panel = 0;
        vsync = 1; fs_h_put = 0; zero = 0; zero3 = 0;
        total = 0; bad = 0; left_rises = 0; right_rises = 0; put_rises = 0; err_rises = 0;
        prev_l = 0; prev_r = 0; prev_p = 0; prev_e = 0;
        mdl_cursor = 3'd3; mdl_over = 0; chk_en = 0;
        @(negedge clk); #1;
        chk_en = 1;
        cyc();
        rst = 1;
        cyc(); cyc();

        // human put; a left request mid-sequence is dropped
        human(0, 0, 1, 0);
        repeat (2) cyc();
        human(1, 0, 0, 0);
        wait_idle();
        chk("put_pulses", put_rises, 1);
        chk("cursor_after_put", cursor, 3);

        // seven lefts stop at column 0
        repeat (7) begin
            human(1, 0, 0, 0);
            wait_idle();
        end
        chk("left_pulses", left_rises, 3);
        chk("cursor_at_0", cursor, 0);
        chk("model_cursor_at_0", mdl_cursor, 0);

        // automated moves: 0->3, 3->6, then same column
        player = 1; cyc();
        human(0, 0, 1, 0);
        auto_move(3'd3, 0); wait_idle();
        r0 = right_rises;
        auto_move(3'd6, 0); wait_idle();
        chk("right_pulses_3to6", right_rises - r0, 3);
        chk("cursor_at_6", cursor, 6);
        p0 = put_rises;
        auto_move(3'd6, 0); wait_idle();
        chk("zero_step_put", put_rises - p0, 1);
        chk("zero_step_no_right", right_rises - r0, 3);

        // bad column, then invalid move after an automated put
        e0 = err_rises;
        auto_move(3'd7, 0); wait_idle();
        chk("err_bad_col", err_rises - e0, 1);
        auto_move(3'd5, 1); wait_idle();
        invalid_move = 0;
        chk("err_invalid", err_rises - e0, 2);
        chk("cursor_at_5", cursor, 5);

        // human side: auto ignored, right edge, priorities, invalid on human put
        player = 0; cyc();
        auto_move(3'd2, 0); wait_idle();
        human(0, 1, 0, 0); wait_idle();
        human(0, 1, 0, 0); wait_idle();
        human(1, 1, 0, 0); wait_idle();
        invalid_move = 1;
        p0 = put_rises;
        human(1, 0, 1, 0); wait_idle();
        invalid_move = 0;
        chk("put_priority", put_rises - p0, 1);
        chk("cursor_at_5b", cursor, 5);
        chk("no_err_human", err_rises - e0, 2);

        // win during settle locks everything out
        human(0, 0, 1, 1);
        repeat (6) cyc();
        win_a = 1;
        wait_idle();
        chk("game_over_set", game_over, 1);
        p0 = put_rises;
        human(0, 0, 1, 0);
        player = 1; cyc();
        auto_move(3'd1, 0);
        repeat (3) cyc();
        chk("over_no_put", put_rises - p0, 0);

        do_reset();
        cyc(); cyc();
        rst = 1;
        chk("reset_cursor", cursor, 3);
        chk("reset_game_over", game_over, 0);
        player = 0; cyc();

        // reset in the middle of a step pulse
        human(0, 1, 0, 0); wait_idle();
        human(0, 1, 0, 0);
        cyc();
        do_reset();
        cyc();
        chk("rst_mid_right", right, 0);
        chk("rst_mid_cursor", cursor, 3);
        rst = 1;
        cyc();

        // frame-synchronised put waits for a vsync falling edge
        fs_h_put = 1; cyc(); fs_h_put = 0;
        repeat (4) begin
            chk("fs_put_wait", fs_put, 0);
            cyc();
        end
        chk("fs_busy_wait", fs_busy, 1);
        vsync = 0;
        cyc();
        for (int i = 0; i < PULSE; i++) begin
            chk("fs_put_high", fs_put, 1);
            cyc();
        end
        chk("fs_put_done", fs_put, 0);
        vsync = 1;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/score4_move_sequencer.md
Name: score4_move_sequencer

Overview:
- Sits between the move sources and the score4 game core: human button requests on one side, the automated player's column choice on the other.
- Owns the core's left/right/put inputs and grants them according to the core's `player` turn flag.
- Turns an automated target column into timed left/right step pulses followed by a put pulse.
- Locks out all moves once the core reports a win or a full panel.

Parameters:
- NCOLS, 7: number of panel columns.
- COL_START, 3: cursor column after reset; must equal the core's reset cursor.
- PULSE_LEN, 3: cycles each left/right/put pulse is held high.
- GAP_LEN, 4: idle cycles after each step pulse.
- SETTLE_LEN, 8: cycles waited after a put before status is sampled.
- FRAME_SYNC, 0: when 1, every pulse starts only on the cycle after a vsync falling edge.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-low reset.
- h_left, in, 1: human move-left request, one-cycle pulse.
- h_right, in, 1: human move-right request, one-cycle pulse.
- h_put, in, 1: human put request, one-cycle pulse.
- auto_valid, in, 1: automated column choice valid.
- auto_col, in, 3: automated target column.
- auto_ready, out, 1: sequencer can accept auto_col.
- player, in, 1: core turn flag; 0 = human, 1 = automated.
- invalid_move, in, 1: core status.
- win_a, in, 1: core status.
- win_b, in, 1: core status.
- full_panel, in, 1: core status.
- vsync, in, 1: VGA vsync from the core.
- left, out, 1: to core.
- right, out, 1: to core.
- put, out, 1: to core.
- cursor, out, 3: tracked cursor column.
- busy, out, 1: sequence in progress.
- err_col, out, 1: one-cycle error pulse.
- game_over, out, 1: game-over lockout flag.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst is synchronous and active-low; when low at a posedge, the next state is reset regardless of any sequence in progress.
  - Reset values: left = right = put = 0, auto_ready = 0, busy = 0, err_col = 0, game_over = 0, cursor = COL_START, state = IDLE.
- States:
  - IDLE: no sequence running; arbitrates requests.
  - STEP: drives left or right for PULSE_LEN cycles.
  - GAP: drives nothing for GAP_LEN cycles.
  - PUT: drives put for PULSE_LEN cycles.
  - SETTLE: waits SETTLE_LEN cycles, then samples status.
  - OVER: lockout until reset.
- IDLE, player = 0:
  - A human pulse is accepted in the cycle it is seen.
  - If more than one pulse is seen in the same cycle, priority is put > left > right; the others are dropped.
  - h_left at cursor 0, or h_right at cursor NCOLS-1, is dropped; no pulse is issued.
  - An accepted left/right runs STEP, then GAP, then returns to IDLE.
  - An accepted put runs PUT, then SETTLE, then returns to IDLE.
- IDLE, player = 1:
  - auto_ready = 1; it is 0 in every other state and whenever player = 0.
  - A transfer happens when auto_valid and auto_ready are both 1.
  - If auto_col >= NCOLS: err_col pulses for one cycle and the sequencer stays in IDLE.
  - Otherwise: steps = |auto_col - cursor|, direction = sign of the difference. The sequencer runs STEP, then GAP, once per step, then PUT, then SETTLE. With steps = 0 it goes directly to PUT.
- Dropped inputs:
  - Human pulses while busy = 1 or while player = 1 are dropped.
  - auto_valid while player = 0 is ignored.
- Timing and cursor:
  - From acceptance in cycle T, the first pulse is high in cycles T+1 through T+PULSE_LEN.
  - busy = 1 from T+1 until the cycle the sequencer re-enters IDLE.
  - cursor updates by ±1 on the last cycle of each step pulse and never leaves the range 0..NCOLS-1.
- FRAME_SYNC = 1:
  - Entry into STEP or PUT waits, with outputs low, until the cycle after a falling edge of vsync.
  - The cycle counts of the other phases are unchanged.
- End of SETTLE:
  - If win_a, win_b or full_panel is 1, go to OVER.
  - Otherwise, if invalid_move = 1 and the sequence came from the automated player, pulse err_col for one cycle.
  - Then return to IDLE.
- OVER:
  - A status flag high in any IDLE cycle also forces OVER.
  - In OVER: game_over = 1, all move outputs are 0, auto_ready = 0, and all requests are ignored.
  - Only reset leaves OVER.

Test Plan:
- Reset, then player = 0, h_put pulse: put high for exactly 3 cycles starting 1 cycle after the pulse; busy low after 3+8 cycles; cursor stays 3.
- player = 0, h_left seven times, each sent after busy falls: exactly three left pulses are issued; cursor goes 3→2→1→0 and stays 0.
- player = 1, auto_valid with auto_col = 6 and cursor = 3: three right pulses, each 3 high cycles then 4 low; then one put; cursor ends at 6; auto_ready is 0 throughout.
- player = 1, auto_col = 7: err_col pulses once, no move pulses are issued, auto_ready stays 1. Separately, invalid_move = 1 at the end of SETTLE after an automated put: err_col pulses once and the sequencer returns to IDLE.
- win_a raised during SETTLE: game_over = 1 at SETTLE end, and later h_put and auto_valid produce no outputs. Driving rst = 0 in the middle of a STEP pulse clears all outputs at the next edge and sets cursor = 3.
- FRAME_SYNC = 1 with a human put: put rises only on the cycle after a vsync falling edge.
